// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the 2x4 decoder / 4x2 encoder pair.
// onehot2idx is also used by the decoder bench to turn strobes back into codes.
package encoder_pkg;

  localparam int N_EV   = 4;
  localparam int CODE_W = 2;

  // EMPTY/FULL describes the single output slot; valid is FULL.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // A zero input gives 0; multi-hot inputs OR their indices together.
  function automatic logic [CODE_W-1:0] onehot2idx(input logic [N_EV-1:0] oh);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_EV; i++) begin
      if (oh[i]) idx = idx | CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/encoder4x2_seq_if.sv
// Event-in / code-out bundle of the 4x2 encoder; master drives requests and
// ready, slave (the encoder) returns code/valid plus pend and drop status.
interface encoder4x2_seq_if;
  import encoder_pkg::*;

  logic              en;
  logic [N_EV-1:0]   req;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic              ready;
  logic [N_EV-1:0]   pend;
  logic              drop;

  modport master (
    output en, req, ready,
    input  code, valid, pend, drop
  );

  modport slave (
    input  en, req, ready,
    output code, valid, pend, drop
  );

endinterface

// File: rtl/encoder4x2_seq_pick.sv
// Fixed-priority picker over four pending bits, purely combinational.
// LSB_FIRST=0 favours bit 3, LSB_FIRST=1 favours bit 0.
module prio_pick4
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic [N_EV-1:0]   vec,
  output logic [CODE_W-1:0] idx,
  output logic              hit,
  output logic [N_EV-1:0]   onehot
);

  // The last set bit visited in the scan wins, so scan towards the winner.
  generate
    if (LSB_FIRST) begin : g_lsb
      always_comb begin
        onehot = '0;
        for (int i = N_EV - 1; i >= 0; i--) begin
          if (vec[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
          end
        end
      end
    end else begin : g_msb
      always_comb begin
        onehot = '0;
        for (int i = 0; i < N_EV; i++) begin
          if (vec[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
          end
        end
      end
    end
  endgenerate

  assign hit = |vec;
  assign idx = onehot2idx(onehot);

endmodule

// File: rtl/encoder4x2_seq.sv
// Queues request pulses as pending bits and serves them one per cycle as a 2-bit code.
// Latency 2 edges req->valid; valid/code hold while ready is low, no comb path to outputs.
module encoder4x2_seq
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  encoder4x2_seq_if.slave    bus
);

  state_t            state_q, state_d;
  logic [N_EV-1:0]   pend_q, pend_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              drop_q, drop_d;

  logic [N_EV-1:0]   new_ev;
  logic [N_EV-1:0]   take;
  logic              slot_free;
  logic [CODE_W-1:0] pick_idx;
  logic              pick_hit;
  logic [N_EV-1:0]   pick_oh;

  prio_pick4 #(
    .LSB_FIRST (LSB_FIRST)
  ) u_pick (
    .vec    (pend_q),
    .idx    (pick_idx),
    .hit    (pick_hit),
    .onehot (pick_oh)
  );

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    take      = '0;
    slot_free = (state_q == ST_EMPTY) || bus.ready;
    new_ev    = bus.req & {N_EV{bus.en}};

    if (slot_free) begin
      if (pick_hit) begin
        take    = pick_oh;
        code_d  = pick_idx;
        state_d = ST_FULL;
      end else begin
        state_d = ST_EMPTY;
      end
    end

    // A fresh request on the bit being taken re-queues it rather than dropping.
    pend_d = (pend_q & ~take) | new_ev;
    drop_d = drop_q | (|(new_ev & pend_q & ~take));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      pend_q  <= '0;
      code_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.code  = code_q;
  assign bus.valid = (state_q == ST_FULL);
  assign bus.pend  = pend_q;
  assign bus.drop  = drop_q;

  // Stalled output must not change under the consumer.
  a_hold_on_stall : assert property (
    @(posedge clk) disable iff (rst)
    (state_q == ST_FULL && !bus.ready) |=> (state_q == ST_FULL && $stable(code_q))
  );

  a_drop_sticky : assert property (
    @(posedge clk) disable iff (rst)
    drop_q |=> drop_q
  );

endmodule

// File: tb/tb_encoder4x2_seq.sv
module tb_encoder4x2_seq;
  import encoder_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  encoder4x2_seq_if if0 ();
  encoder4x2_seq_if if1 ();

  encoder4x2_seq #(.LSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  encoder4x2_seq #(.LSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic en, input logic [3:0] req, input logic ready);
    if0.en = en; if0.req = req; if0.ready = ready;
    if1.en = en; if1.req = req; if1.ready = ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed vector for a DUT: {pend, code, valid, drop}
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 4'b0000, 1'b0);
    step(); step();
    checks++;
    if ({if0.pend, if0.code, if0.valid, if0.drop} !== 8'b0000_00_0_0) begin
      failures++;
      $display("FAIL reset0: got %b expected %b", {if0.pend, if0.code, if0.valid, if0.drop}, 8'b0000_00_0_0);
    end
    checks++;
    if ({if1.pend, if1.code, if1.valid, if1.drop} !== 8'b0000_00_0_0) begin
      failures++;
      $display("FAIL reset1: got %b expected %b", {if1.pend, if1.code, if1.valid, if1.drop}, 8'b0000_00_0_0);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    drive(1'b1, 4'b0100, 1'b1);
    step();
    checks++;
    if ({if0.pend, if0.valid} !== 5'b0100_0) begin
      failures++;
      $display("FAIL single_e0: got %b expected %b", {if0.pend, if0.valid}, 5'b0100_0);
    end
    drive(1'b1, 4'b0000, 1'b1);
    step();
    checks++;
    if ({if0.pend, if0.code, if0.valid} !== 7'b0000_10_1) begin
      failures++;
      $display("FAIL single_e1: got %b expected %b", {if0.pend, if0.code, if0.valid}, 7'b0000_10_1);
    end
    step();
    checks++;
    if (if0.valid !== 1'b0) begin
      failures++;
      $display("FAIL single_e2: got %b expected %b", if0.valid, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp0 [3];
    logic [1:0] exp1 [3];
    exp0 = '{2'b11, 2'b01, 2'b00};
    exp1 = '{2'b00, 2'b01, 2'b11};
    drive(1'b1, 4'b1011, 1'b1);
    step();
    checks++;
    if (if0.pend !== 4'b1011) begin
      failures++;
      $display("FAIL b2b_pend: got %b expected %b", if0.pend, 4'b1011);
    end
    drive(1'b1, 4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({if0.code, if0.valid} !== {exp0[k], 1'b1}) begin
        failures++;
        $display("FAIL b2b_msb[%0d]: got %b expected %b", k, {if0.code, if0.valid}, {exp0[k], 1'b1});
      end
      checks++;
      if ({if1.code, if1.valid} !== {exp1[k], 1'b1}) begin
        failures++;
        $display("FAIL b2b_lsb[%0d]: got %b expected %b", k, {if1.code, if1.valid}, {exp1[k], 1'b1});
      end
    end
    step();
    checks++;
    if ({if0.valid, if1.valid} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_empty: got %b expected %b", {if0.valid, if1.valid}, 2'b00);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 4'b0011, 1'b0);
    step();
    drive(1'b1, 4'b0000, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({if0.pend, if0.code, if0.valid} !== 7'b0001_01_1) begin
        failures++;
        $display("FAIL stall[%0d]: got %b expected %b", k, {if0.pend, if0.code, if0.valid}, 7'b0001_01_1);
      end
      step();
    end
    drive(1'b1, 4'b0000, 1'b1);
    step();
    checks++;
    if ({if0.pend, if0.code, if0.valid} !== 7'b0000_00_1) begin
      failures++;
      $display("FAIL stall_next: got %b expected %b", {if0.pend, if0.code, if0.valid}, 7'b0000_00_1);
    end
    step();
    checks++;
    if ({if0.valid, if1.valid} !== 2'b00) begin
      failures++;
      $display("FAIL stall_empty: got %b expected %b", {if0.valid, if1.valid}, 2'b00);
    end
  endtask

  task automatic test_drop();
    drive(1'b1, 4'b1000, 1'b0);
    step();
    drive(1'b1, 4'b0000, 1'b0);
    step();
    checks++;
    if ({if0.pend, if0.code, if0.valid, if0.drop} !== 8'b0000_11_1_0) begin
      failures++;
      $display("FAIL drop_load: got %b expected %b", {if0.pend, if0.code, if0.valid, if0.drop}, 8'b0000_11_1_0);
    end
    drive(1'b1, 4'b0001, 1'b0);
    step();
    checks++;
    if ({if0.pend, if0.drop} !== 5'b0001_0) begin
      failures++;
      $display("FAIL drop_first: got %b expected %b", {if0.pend, if0.drop}, 5'b0001_0);
    end
    step();
    checks++;
    if ({if0.pend, if0.drop, if1.drop} !== 6'b0001_1_1) begin
      failures++;
      $display("FAIL drop_second: got %b expected %b", {if0.pend, if0.drop, if1.drop}, 6'b0001_1_1);
    end
    drive(1'b1, 4'b0000, 1'b1);
    step();
    checks++;
    if ({if0.pend, if0.code, if0.valid} !== 7'b0000_00_1) begin
      failures++;
      $display("FAIL drop_deliver: got %b expected %b", {if0.pend, if0.code, if0.valid}, 7'b0000_00_1);
    end
    step();
    step();
    checks++;
    if ({if0.valid, if0.drop} !== 2'b0_1) begin
      failures++;
      $display("FAIL drop_sticky: got %b expected %b", {if0.valid, if0.drop}, 2'b0_1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({if0.drop, if1.drop} !== 2'b00) begin
      failures++;
      $display("FAIL drop_clear: got %b expected %b", {if0.drop, if1.drop}, 2'b00);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 4'b0010, 1'b1);
    step();
    step();
    checks++;
    if ({if0.pend, if0.code, if0.valid, if0.drop} !== 8'b0010_01_1_0) begin
      failures++;
      $display("FAIL coll_first: got %b expected %b", {if0.pend, if0.code, if0.valid, if0.drop}, 8'b0010_01_1_0);
    end
    drive(1'b1, 4'b0000, 1'b1);
    step();
    checks++;
    if ({if0.pend, if0.code, if0.valid, if0.drop} !== 8'b0000_01_1_0) begin
      failures++;
      $display("FAIL coll_second: got %b expected %b", {if0.pend, if0.code, if0.valid, if0.drop}, 8'b0000_01_1_0);
    end
    step();
    checks++;
    if ({if0.valid, if0.drop} !== 2'b0_0) begin
      failures++;
      $display("FAIL coll_end: got %b expected %b", {if0.valid, if0.drop}, 2'b0_0);
    end
  endtask

  task automatic test_en_and_reset();
    drive(1'b0, 4'b1111, 1'b1);
    step();
    step();
    checks++;
    if ({if0.pend, if0.valid, if1.pend, if1.valid} !== 10'b0000_0_0000_0) begin
      failures++;
      $display("FAIL en_off: got %b expected %b", {if0.pend, if0.valid, if1.pend, if1.valid}, 10'b0000_0_0000_0);
    end
    drive(1'b1, 4'b0010, 1'b0);
    step();
    drive(1'b1, 4'b1100, 1'b0);
    step();
    checks++;
    if ({if0.pend, if0.code, if0.valid} !== 7'b1100_01_1) begin
      failures++;
      $display("FAIL midstream: got %b expected %b", {if0.pend, if0.code, if0.valid}, 7'b1100_01_1);
    end
    rst = 1'b1;
    drive(1'b1, 4'b1111, 1'b1);
    step();
    checks++;
    if ({if0.pend, if0.code, if0.valid, if0.drop} !== 8'b0000_00_0_0) begin
      failures++;
      $display("FAIL rst_mid0: got %b expected %b", {if0.pend, if0.code, if0.valid, if0.drop}, 8'b0000_00_0_0);
    end
    checks++;
    if ({if1.pend, if1.code, if1.valid, if1.drop} !== 8'b0000_00_0_0) begin
      failures++;
      $display("FAIL rst_mid1: got %b expected %b", {if1.pend, if1.code, if1.valid, if1.drop}, 8'b0000_00_0_0);
    end
    rst = 1'b0;
    drive(1'b0, 4'b0000, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_drop();
    test_collision();
    test_en_and_reset();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
